bram_port_arbiter: RTL and testbench

//  Shares one port of the 32-bit byte-write dual-port block RAM between two requesters.

---
 rtl/bram_port_arbiter.sv | 118 +++++++++++
 tb/tb_bram_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for one 32-bit byte-write block RAM port.
// Grants one access per cycle and returns 1-cycle read data to its owner.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   m0_* / m1_*         requester ports: req/addr/we/wdata in, ack/rdata/rvalid out
//   ram_clken/addr/we/din  RAM port drive
//   ram_dout            RAM read data (1-cycle latency)
module bram_port_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [3:0]            m0_we,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_ack,
    output logic [31:0]           m0_rdata,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [3:0]            m1_we,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_ack,
    output logic [31:0]           m1_rdata,
    output logic                  m1_rvalid,
    output logic                  ram_clken,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;
    logic       last_gnt_q, last_gnt_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;

    logic act0, act1;
    logic gnt0, gnt1;

    // Requests are masked during reset so nothing reaches the RAM.
    assign act0 = rst_n & m0_req;
    assign act1 = rst_n & m1_req;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (act0 && act1) begin
            if (FIXED_PRIO != 0) begin
                if (starve_cnt_q == LIMIT) gnt1 = 1'b1;
                else                       gnt0 = 1'b1;
            end else begin
                // last_gnt_q: 0 = m0, 1 = m1; grant the other one
                if (last_gnt_q) gnt0 = 1'b1;
                else            gnt1 = 1'b1;
            end
        end else begin
            gnt0 = act0;
            gnt1 = act1;
        end
    end

    assign m0_ack = gnt0;
    assign m1_ack = gnt1;

    // RAM drive: idle cycles keep m0 address/data, but never write.
    assign ram_clken = gnt0 | gnt1;
    assign ram_addr  = gnt1 ? m1_addr  : m0_addr;
    assign ram_din   = gnt1 ? m1_wdata : m0_wdata;
    assign ram_we    = gnt1 ? m1_we : (gnt0 ? m0_we : 4'b0000);

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0) last_gnt_d = 1'b0;
        if (gnt1) last_gnt_d = 1'b1;
    end

    // Wait counter for m1, saturating so the override stays asserted.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m1_req || gnt1)
            starve_cnt_d = 8'd0;
        else if (starve_cnt_q != LIMIT)
            starve_cnt_d = starve_cnt_q + 8'd1;
    end

    always_comb begin
        rd_pend_d  = (gnt0 && (m0_we == 4'b0000)) ||
                     (gnt1 && (m1_we == 4'b0000));
        rd_owner_d = rd_pend_d ? gnt1 : rd_owner_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            last_gnt_q   <= 1'b1;
            starve_cnt_q <= 8'd0;
        end else begin
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            last_gnt_q   <= last_gnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign m0_rvalid = rd_pend_q & ~rd_owner_q;
    assign m1_rvalid = rd_pend_q &  rd_owner_q;
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: dut a round-robin,
// dut b fixed priority with STARVE_LIMIT=3, both on shared stimulus.
module tb_bram_port_arbiter;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b1;
    logic [11:0] m0_addr = '0;
    logic [3:0]  m0_we = '0;
    logic [31:0] m0_wdata = '0;
    logic        m1_req = 1'b1;
    logic [11:0] m1_addr = '0;
    logic [3:0]  m1_we = '0;
    logic [31:0] m1_wdata = '0;

    logic [1:0]  ack_a, ack_b;
    logic [3:0]  rv;
    logic [31:0] rd [4];
    logic        clken_a, clken_b;
    logic [11:0] addr_a, addr_b;
    logic [3:0]  we_a, we_b;
    logic [31:0] din_a, din_b;
    logic [31:0] dout_a, dout_b;
    logic [31:0] mem_a [4096];
    logic [31:0] mem_b [4096];

    int   errors = 0;
    int   checks = 0;
    int   cyc_n = 0;
    logic expect_rv = 1'b1;
    logic done = 1'b0;

    logic [1:0] gq [2][$];
    exp_t       rq [4][$];

    logic [1:0] tie_a [15];
    logic [1:0] tie_b [15];

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    bram_port_arbiter #(.ADDR_WIDTH(12), .FIXED_PRIO(0), .STARVE_LIMIT(8)) u_a (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m0_ack(ack_a[0]), .m0_rdata(rd[0]), .m0_rvalid(rv[0]),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m1_ack(ack_a[1]), .m1_rdata(rd[1]), .m1_rvalid(rv[1]),
        .ram_clken(clken_a), .ram_addr(addr_a), .ram_we(we_a),
        .ram_din(din_a), .ram_dout(dout_a)
    );

    bram_port_arbiter #(.ADDR_WIDTH(12), .FIXED_PRIO(1), .STARVE_LIMIT(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m0_ack(ack_b[0]), .m0_rdata(rd[2]), .m0_rvalid(rv[2]),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m1_ack(ack_b[1]), .m1_rdata(rd[3]), .m1_rvalid(rv[3]),
        .ram_clken(clken_b), .ram_addr(addr_b), .ram_we(we_b),
        .ram_din(din_b), .ram_dout(dout_b)
    );

    // Byte-write RAMs with 1-cycle read latency, output held while idle.
    always @(posedge clk) begin
        if (clken_a) begin
            for (int i = 0; i < 4; i++)
                if (we_a[i]) mem_a[addr_a][8*i +: 8] <= din_a[8*i +: 8];
            dout_a <= mem_a[addr_a];
        end
        if (clken_b) begin
            for (int i = 0; i < 4; i++)
                if (we_b[i]) mem_b[addr_b][8*i +: 8] <= din_b[8*i +: 8];
            dout_b <= mem_b[addr_b];
        end
    end

    task automatic cyc(input logic rs,
                       input logic r0, input logic [11:0] a0, input logic [3:0] w0,
                       input logic r1, input logic [11:0] a1, input logic [3:0] w1,
                       input logic [31:0] wd1,
                       input logic [1:0] ea, input logic [1:0] eb,
                       input logic [31:0] d0, input logic [31:0] d1);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rs;
        m0_req = r0; m0_addr = a0; m0_we = w0;
        m1_req = r1; m1_addr = a1; m1_we = w1; m1_wdata = wd1;
        gq[0].push_back(ea);
        gq[1].push_back(eb);
        e.cyc = cyc_n;
        if (expect_rv) begin
            e.data = d0;
            if (ea[0] && w0 == 4'b0000) rq[0].push_back(e);
            if (eb[0] && w0 == 4'b0000) rq[2].push_back(e);
            e.data = d1;
            if (ea[1] && w1 == 4'b0000) rq[1].push_back(e);
            if (eb[1] && w1 == 4'b0000) rq[3].push_back(e);
        end
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 12'h0, 4'h0, 1'b0, 12'h0, 4'h0, 32'h0,
            2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    // Monitor: grants every cycle, read returns against the scoreboard.
    logic [1:0] m_g, m_ga;
    logic       m_ck;
    logic [3:0] m_we;
    exp_t       m_e;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (gq[d].size() > 0) begin
                m_g  = gq[d].pop_front();
                m_ga = (d == 1) ? ack_b : ack_a;
                m_ck = (d == 1) ? clken_b : clken_a;
                m_we = (d == 1) ? we_b : we_a;
                checks++;
                if (m_ga !== m_g) begin
                    errors++;
                    $display("FAIL grant dut%0d cyc=%0d got=%b exp=%b",
                             d, cyc_n, m_ga, m_g);
                end
                checks++;
                if (m_ck !== (|m_g) || (m_g == 2'b00 && m_we !== 4'b0000)) begin
                    errors++;
                    $display("FAIL ramport dut%0d cyc=%0d clken=%b we=%b exp_clken=%b",
                             d, cyc_n, m_ck, m_we, |m_g);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (rq[k].size() > 0 && rq[k][0].cyc + 1 == cyc_n) begin
                m_e = rq[k].pop_front();
                checks++;
                if (rv[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL rvalid_missing port%0d cyc=%0d got=%b exp=1",
                             k, cyc_n, rv[k]);
                end else if (rd[k] !== m_e.data) begin
                    errors++;
                    $display("FAIL rdata port%0d cyc=%0d got=%h exp=%h",
                             k, cyc_n, rd[k], m_e.data);
                end
            end else if (rv[k] === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected port%0d cyc=%0d got=1 exp=0",
                         k, cyc_n);
            end
        end
        if (done) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rq[k].size() != 0) begin
                    errors++;
                    $display("FAIL pending port%0d left=%0d exp=0", k, rq[k].size());
                end
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[12'h010] = 32'hDEADBEEF; mem_b[12'h010] = 32'hDEADBEEF;
        mem_a[12'h030] = 32'hCAFEF00D; mem_b[12'h030] = 32'hCAFEF00D;
        tie_a = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10,
                  2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        tie_b = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10,
                  2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        // reset with both requesting
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 12'h010, 4'h0, 1'b1, 12'h030, 4'h0, 32'h0,
                2'b00, 2'b00, 32'h0, 32'h0);
        idle();

        // single read
        cyc(1'b1, 1'b1, 12'h010, 4'h0, 1'b0, 12'h0, 4'h0, 32'h0,
            2'b01, 2'b01, 32'hDEADBEEF, 32'h0);
        idle();

        // byte write then read-back
        cyc(1'b1, 1'b0, 12'h0, 4'h0, 1'b1, 12'h020, 4'b0100, 32'h12345678,
            2'b10, 2'b10, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 12'h0, 4'h0, 1'b1, 12'h020, 4'b0000, 32'h0,
            2'b10, 2'b10, 32'h0, 32'h00340000);
        idle();

        // ties: round-robin vs starvation override, m1 drop at step 10
        for (int i = 0; i < 15; i++)
            cyc(1'b1, 1'b1, 12'h010, 4'h0, (i != 10), 12'h030, 4'h0, 32'h0,
                tie_a[i], tie_b[i], 32'hDEADBEEF, 32'hCAFEF00D);
        idle();

        // reset lands on the edge after a read is acked
        expect_rv = 1'b0;
        cyc(1'b1, 1'b1, 12'h010, 4'h0, 1'b0, 12'h0, 4'h0, 32'h0,
            2'b01, 2'b01, 32'h0, 32'h0);
        expect_rv = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        cyc(1'b0, 1'b1, 12'h010, 4'h0, 1'b1, 12'h030, 4'h0, 32'h0,
            2'b00, 2'b00, 32'h0, 32'h0);
        cyc(1'b1, 1'b1, 12'h010, 4'h0, 1'b1, 12'h030, 4'h0, 32'h0,
            2'b01, 2'b01, 32'hDEADBEEF, 32'h0);
        idle();
        idle();

        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
